// File: rtl/cp0_reg.sv
// ---------------------------------------------------------------------------
// cp0_reg -- Coprocessor-0 register file, writeback stage.
//
// Holds the Count/Compare timer, Status, Cause, EPC, BadVAddr and the
// read-only PRId/Config registers. Software writes arrive as the registered
// (we/addr/data) triple from MEM/WB; exception and eret events arrive from
// the exception unit and take priority over a software write in the same
// cycle.
//
// Ports:
//   clk                 clock, rising edge
//   resetn              asynchronous active-low reset
//   we_i/waddr_i/wdata_i  CP0 write triple from MEM/WB
//   raddr_i             mfc0 read register number
//   int_i               external hardware interrupt lines (Cause.IP[7:2])
//   exc_valid_i         exception taken this cycle
//   exc_code_i          Cause.ExcCode for the exception
//   exc_pc_i            PC of the faulting instruction
//   exc_in_delayslot_i  faulting instruction sits in a delay slot
//   exc_badaddr_i       faulting address (latched for AdEL/AdES)
//   eret_i              eret committing this cycle
//   rdata_o             combinational read data (no write bypass)
//   count_o ... epc_o   live register values
//   timer_int_o         sticky timer interrupt pending
// ---------------------------------------------------------------------------
module cp0_reg #(
   parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
   parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_i,
   input  logic [5:0]  int_i,
   input  logic        exc_valid_i,
   input  logic [4:0]  exc_code_i,
   input  logic [31:0] exc_pc_i,
   input  logic        exc_in_delayslot_i,
   input  logic [31:0] exc_badaddr_i,
   input  logic        eret_i,
   output logic [31:0] rdata_o,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic [31:0] status_o,
   output logic [31:0] cause_o,
   output logic [31:0] epc_o,
   output logic        timer_int_o
);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;
   localparam logic [4:0] REG_PRID     = 5'd15;
   localparam logic [4:0] REG_CONFIG   = 5'd16;

   localparam logic [31:0] STATUS_RST = 32'h1000_0000;

   // AdEL / AdES are the only codes that carry a bad address.
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   logic [31:0] count_reg;
   logic [31:0] compare_reg;
   logic [31:0] status_reg;
   logic [31:0] epc_reg;
   logic [31:0] badvaddr_reg;
   logic        timer_int_reg;

   // Cause is kept as its individual fields; unused bits are hard zero.
   logic        cause_bd_reg;
   logic        cause_iv_reg;
   logic        cause_wp_reg;
   logic [5:0]  cause_ip_hw_reg;
   logic [1:0]  cause_ip_sw_reg;
   logic [4:0]  cause_exccode_reg;

   logic wr_count;
   logic wr_compare;
   logic wr_status;
   logic wr_cause;
   logic wr_epc;
   logic exl_cur;
   logic timer_hit;
   logic [31:0] epc_next;

   assign wr_count   = we_i && (waddr_i == REG_COUNT);
   assign wr_compare = we_i && (waddr_i == REG_COMPARE);
   assign wr_status  = we_i && (waddr_i == REG_STATUS);
   assign wr_cause   = we_i && (waddr_i == REG_CAUSE);
   assign wr_epc     = we_i && (waddr_i == REG_EPC);

   // EXL before this edge decides whether a nested exception records EPC/BD.
   assign exl_cur   = status_reg[1];
   // Match against the pre-increment Count; Compare==0 disables the timer.
   assign timer_hit = (compare_reg != 32'd0) && (count_reg == compare_reg);
   // A delay-slot fault restarts at the branch, one word earlier.
   assign epc_next  = exc_in_delayslot_i ? (exc_pc_i - 32'd4) : exc_pc_i;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_reg         <= 32'd0;
         compare_reg       <= 32'd0;
         status_reg        <= STATUS_RST;
         epc_reg           <= 32'd0;
         badvaddr_reg      <= 32'd0;
         timer_int_reg     <= 1'b0;
         cause_bd_reg      <= 1'b0;
         cause_iv_reg      <= 1'b0;
         cause_wp_reg      <= 1'b0;
         cause_ip_hw_reg   <= 6'd0;
         cause_ip_sw_reg   <= 2'd0;
         cause_exccode_reg <= 5'd0;
      end else begin
         // Count: a write replaces this cycle's increment.
         if (wr_count) begin
            count_reg <= wdata_i;
         end else begin
            count_reg <= count_reg + 32'd1;
         end

         // Compare write both loads Compare and acknowledges the interrupt.
         if (wr_compare) begin
            compare_reg   <= wdata_i;
            timer_int_reg <= 1'b0;
         end else if (timer_hit) begin
            timer_int_reg <= 1'b1;
         end

         // Hardware interrupt lines are sampled unconditionally.
         cause_ip_hw_reg <= int_i;

         if (wr_cause) begin
            cause_iv_reg    <= wdata_i[23];
            cause_wp_reg    <= wdata_i[22];
            cause_ip_sw_reg <= wdata_i[9:8];
         end

         // Status: software write first, then EXL overridden by events
         // (exception over eret over software).
         if (wr_status) begin
            status_reg <= wdata_i;
         end
         if (exc_valid_i) begin
            status_reg[1] <= 1'b1;
         end else if (eret_i) begin
            status_reg[1] <= 1'b0;
         end

         if (exc_valid_i) begin
            cause_exccode_reg <= exc_code_i;
            // With EXL already set, keep the original EPC/BD so the
            // handler can still return to the first faulting instruction.
            if (!exl_cur) begin
               epc_reg      <= epc_next;
               cause_bd_reg <= exc_in_delayslot_i;
            end
            if ((exc_code_i == EXC_ADEL) || (exc_code_i == EXC_ADES)) begin
               badvaddr_reg <= exc_badaddr_i;
            end
         end else if (wr_epc) begin
            epc_reg <= wdata_i;
         end
      end
   end

   assign count_o     = count_reg;
   assign compare_o   = compare_reg;
   assign status_o    = status_reg;
   assign epc_o       = epc_reg;
   assign timer_int_o = timer_int_reg;
   assign cause_o     = {cause_bd_reg, timer_int_reg, 6'd0,
                         cause_iv_reg, cause_wp_reg, 6'd0,
                         cause_ip_hw_reg, cause_ip_sw_reg, 1'b0,
                         cause_exccode_reg, 2'b00};

   // Reads see committed state only; same-cycle writes are forwarded
   // elsewhere in the pipeline.
   always_comb begin
      rdata_o = 32'd0;
      case (raddr_i)
         REG_BADVADDR: rdata_o = badvaddr_reg;
         REG_COUNT:    rdata_o = count_reg;
         REG_COMPARE:  rdata_o = compare_reg;
         REG_STATUS:   rdata_o = status_reg;
         REG_CAUSE:    rdata_o = cause_o;
         REG_EPC:      rdata_o = epc_reg;
         REG_PRID:     rdata_o = PRID_VAL;
         REG_CONFIG:   rdata_o = CONFIG_VAL;
         default:      rdata_o = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_reg.sv
// ---------------------------------------------------------------------------
// tb_cp0_reg -- self-checking bench for cp0_reg.
// A register-level model tracks what every CP0 register must hold; a
// compare process checks all outputs against it on every falling edge.
// Directed stimulus adds hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_cp0_reg;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        we_i = 1'b0;
   logic [4:0]  waddr_i = 5'd0;
   logic [31:0] wdata_i = 32'd0;
   logic [4:0]  raddr_i = 5'd0;
   logic [5:0]  int_i = 6'd0;
   logic        exc_valid_i = 1'b0;
   logic [4:0]  exc_code_i = 5'd0;
   logic [31:0] exc_pc_i = 32'd0;
   logic        exc_in_delayslot_i = 1'b0;
   logic [31:0] exc_badaddr_i = 32'd0;
   logic        eret_i = 1'b0;
   logic [31:0] rdata_o, count_o, compare_o, status_o, cause_o, epc_o;
   logic        timer_int_o;

   int checks = 0;
   int failures = 0;

   cp0_reg dut (
      .clk(clk), .resetn(resetn),
      .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
      .raddr_i(raddr_i), .int_i(int_i),
      .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i),
      .exc_pc_i(exc_pc_i), .exc_in_delayslot_i(exc_in_delayslot_i),
      .exc_badaddr_i(exc_badaddr_i), .eret_i(eret_i),
      .rdata_o(rdata_o), .count_o(count_o), .compare_o(compare_o),
      .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
      .timer_int_o(timer_int_o)
   );

   always #5 clk = ~clk;

   // ---------------- model ----------------
   // m_cause holds every Cause bit except TI, which is derived from m_timer.
   logic [31:0] m_count = 0, m_compare = 0, m_status = 32'h1000_0000;
   logic [31:0] m_cause = 0, m_epc = 0, m_bad = 0;
   logic        m_timer = 0;
   localparam logic [31:0] CAUSE_SW_MASK = 32'h00C0_0300;

   function automatic logic [31:0] m_cause_out();
      return m_cause | ({31'd0, m_timer} << 30);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:  return m_bad;
         5'd9:  return m_count;
         5'd11: return m_compare;
         5'd12: return m_status;
         5'd13: return m_cause_out();
         5'd14: return m_epc;
         5'd15: return 32'h0000_4220;
         5'd16: return 32'h0000_8000;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_count = 0; m_compare = 0; m_status = 32'h1000_0000;
         m_cause = 0; m_epc = 0; m_bad = 0; m_timer = 0;
      end else begin
         logic [31:0] n_count, n_compare, n_status, n_cause, n_epc, n_bad;
         logic        n_timer;
         n_count   = (we_i && waddr_i == 9) ? wdata_i : m_count + 1;
         n_compare = (we_i && waddr_i == 11) ? wdata_i : m_compare;
         if (we_i && waddr_i == 11) n_timer = 0;
         else n_timer = m_timer | ((m_compare != 0) && (m_count == m_compare));
         n_status = (we_i && waddr_i == 12) ? wdata_i : m_status;
         if (exc_valid_i) n_status[1] = 1;
         else if (eret_i) n_status[1] = 0;
         n_cause = m_cause;
         if (we_i && waddr_i == 13)
            n_cause = (n_cause & ~CAUSE_SW_MASK) | (wdata_i & CAUSE_SW_MASK);
         n_cause[15:10] = int_i;
         n_epc = (we_i && waddr_i == 14) ? wdata_i : m_epc;
         n_bad = m_bad;
         if (exc_valid_i) begin
            n_epc = m_epc;
            if (!m_status[1]) begin
               n_epc = exc_in_delayslot_i ? exc_pc_i - 4 : exc_pc_i;
               n_cause[31] = exc_in_delayslot_i;
            end
            n_cause[6:2] = exc_code_i;
            if (exc_code_i == 4 || exc_code_i == 5) n_bad = exc_badaddr_i;
         end
         m_count = n_count; m_compare = n_compare; m_timer = n_timer;
         m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_bad = n_bad;
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("count_o", count_o, m_count);
      check("compare_o", compare_o, m_compare);
      check("status_o", status_o, m_status);
      check("cause_o", cause_o, m_cause_out());
      check("epc_o", epc_o, m_epc);
      check("timer_int_o", {31'd0, timer_int_o}, {31'd0, m_timer});
      check("rdata_o", rdata_o, m_read(raddr_i));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      we_i = 1; waddr_i = a; wdata_i = d;
      tick();
      we_i = 0;
      $display("txn write reg=%0d data=%h", a, d);
   endtask

   task automatic exc(input logic [4:0] code, input logic [31:0] pc,
                      input logic ds, input logic [31:0] bad);
      exc_valid_i = 1; exc_code_i = code; exc_pc_i = pc;
      exc_in_delayslot_i = ds; exc_badaddr_i = bad;
      tick();
      exc_valid_i = 0; exc_in_delayslot_i = 0;
      $display("txn exception code=%0d pc=%h ds=%0d bad=%h", code, pc, ds, bad);
   endtask

   task automatic eret();
      eret_i = 1;
      tick();
      eret_i = 0;
      $display("txn eret");
   endtask

   initial begin
      #1 resetn = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst count", count_o, 32'd0);
      check("rst status", status_o, 32'h1000_0000);
      resetn = 1;
      repeat (10) tick();
      $display("txn idle 10 cycles");
      check("idle count", count_o, 32'd10);
      check("idle status", status_o, 32'h1000_0000);
      check("idle timer", {31'd0, timer_int_o}, 32'd0);

      // Timer
      wr(5'd11, 32'd20);
      wr(5'd9, 32'd15);
      repeat (5) tick();
      check("count at 20", count_o, 32'd20);
      check("timer before", {31'd0, timer_int_o}, 32'd0);
      tick();
      check("timer rise", {31'd0, timer_int_o}, 32'd1);
      check("cause TI set", {31'd0, cause_o[30]}, 32'd1);
      repeat (3) tick();
      check("timer sticky", {31'd0, timer_int_o}, 32'd1);
      wr(5'd11, 32'd100);
      check("timer clear", {31'd0, timer_int_o}, 32'd0);
      check("cause TI clr", {31'd0, cause_o[30]}, 32'd0);
      check("compare 100", compare_o, 32'd100);

      // Exceptions
      raddr_i = 5'd8;
      exc(5'd4, 32'h8000_0010, 1'b1, 32'h1234_5671);
      check("exc epc", epc_o, 32'h8000_000C);
      check("exc bd", {31'd0, cause_o[31]}, 32'd1);
      check("exc code", {27'd0, cause_o[6:2]}, 32'd4);
      check("exc exl", {31'd0, status_o[1]}, 32'd1);
      check("badvaddr", rdata_o, 32'h1234_5671);
      exc(5'd10, 32'h9000_0000, 1'b0, 32'h0);
      check("nested epc", epc_o, 32'h8000_000C);
      check("nested code", {27'd0, cause_o[6:2]}, 32'd10);
      check("nested bd", {31'd0, cause_o[31]}, 32'd1);
      check("badvaddr kept", rdata_o, 32'h1234_5671);
      // exception beats eret on EXL
      eret_i = 1;
      exc(5'd10, 32'h9000_0004, 1'b0, 32'h0);
      eret_i = 0;
      check("exc over eret", {31'd0, status_o[1]}, 32'd1);
      eret();
      check("eret exl", {31'd0, status_o[1]}, 32'd0);

      // EPC write vs exception, same cycle
      we_i = 1; waddr_i = 5'd14; wdata_i = 32'hAAAA_AAAA;
      exc(5'd8, 32'h8000_0100, 1'b0, 32'hDEAD_BEEF);
      we_i = 0;
      check("epc exc wins", epc_o, 32'h8000_0100);
      check("bd cleared", {31'd0, cause_o[31]}, 32'd0);
      check("bad not syscall", rdata_o, 32'h1234_5671);
      eret();
      // Status write alongside exception: EXL forced, rest from write
      we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_FF00;
      exc(5'd8, 32'h8000_0200, 1'b0, 32'h0);
      we_i = 0;
      check("status+exc", status_o, 32'h0000_FF02);
      eret();
      check("status eret", status_o, 32'h0000_FF00);

      // Count wrap
      raddr_i = 5'd9;
      wr(5'd9, 32'hFFFF_FFFE);
      check("count load", rdata_o, 32'hFFFF_FFFE);
      tick(); check("count ff", rdata_o, 32'hFFFF_FFFF);
      tick(); check("count wrap", rdata_o, 32'd0);
      tick(); check("count 1", rdata_o, 32'd1);

      // Cause write mask and IP sampling
      wr(5'd13, 32'hFFFF_FFFF);
      check("cause sw bits", cause_o & CAUSE_SW_MASK, CAUSE_SW_MASK);
      check("cause zeros", cause_o & 32'h3F3F_FC83, 32'd0);
      int_i = 6'b100001;
      tick();
      check("cause ip hw", {26'd0, cause_o[15:10]}, 32'd33);

      // Read-only and unimplemented
      wr(5'd15, 32'h0);
      raddr_i = 5'd15; #1 check("prid", rdata_o, 32'h0000_4220);
      wr(5'd16, 32'h0);
      raddr_i = 5'd16; #1 check("config", rdata_o, 32'h0000_8000);
      wr(5'd3, 32'h5555_5555);
      raddr_i = 5'd3; #1 check("unimpl", rdata_o, 32'd0);
      wr(5'd8, 32'h5555_5555);
      raddr_i = 5'd8; #1 check("badv ro", rdata_o, 32'h1234_5671);

      // Asynchronous reset between edges with a write in flight
      we_i = 1; waddr_i = 5'd14; wdata_i = 32'h1111_1111;
      tick();
      #2 resetn = 0;
      #1;
      $display("txn async reset");
      check("ar count", count_o, 32'd0);
      check("ar compare", compare_o, 32'd0);
      check("ar status", status_o, 32'h1000_0000);
      check("ar cause", cause_o, 32'd0);
      check("ar epc", epc_o, 32'd0);
      check("ar timer", {31'd0, timer_int_o}, 32'd0);
      check("ar badv", rdata_o, 32'd0);
      tick(); tick();
      we_i = 0; int_i = 0;
      resetn = 1;
      repeat (3) tick();
      check("post reset count", count_o, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
